// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/lap state machine, hundredth-second prescaler
// and a BCD MM:SS.hh count that drives the display mux.
module stopwatch_ctrl #(
   parameter int TICK_DIV = 1000000,
   parameter int CNT_W    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_p,
   input  logic        lap_p,
   input  logic        clear_p,
   output logic [23:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        wrap_p
);

   typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} state_t;

   localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
   localparam logic [23:0]      COUNT_MAX = 24'h595999;
   // Per-digit rollover limits, index 0 = hundredths ones up to 5 = minutes tens
   localparam logic [3:0] DIGIT_MAX [6] = '{4'd9, 4'd9, 4'd9, 4'd5, 4'd9, 4'd5};

   state_t           state;
   logic [CNT_W-1:0] presc;
   logic [23:0]      live_cnt;
   logic [23:0]      live_inc;
   logic [23:0]      lap_reg;
   logic             wrap_pend;
   logic             counting;
   logic             tick;
   logic             at_max;

   assign counting = (state == RUN) || (state == LAP);
   assign tick     = counting && (presc == PRESC_MAX);
   assign at_max   = (live_cnt == COUNT_MAX);

   // Ripple the +1 through the digits; a digit at its limit goes to 0 and carries
   always_comb begin
      logic carry;
      live_inc = live_cnt;
      carry    = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (live_cnt[i*4 +: 4] >= DIGIT_MAX[i]) begin
               live_inc[i*4 +: 4] = 4'd0;
            end else begin
               live_inc[i*4 +: 4] = live_cnt[i*4 +: 4] + 4'd1;
               carry              = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         presc      <= '0;
         live_cnt   <= '0;
         lap_reg    <= '0;
         wrap_pend  <= 1'b0;
         disp_bcd   <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         wrap_p     <= 1'b0;
      end else begin
         disp_bcd  <= (state == LAP) ? lap_reg : live_cnt;
         wrap_pend <= tick && at_max;
         wrap_p    <= wrap_pend;

         if (counting) begin
            presc <= tick ? '0 : presc + CNT_W'(1);
         end
         if (tick) begin
            live_cnt <= live_inc;
         end

         // Each state only looks at its legal pulses, highest priority first
         case (state)
            IDLE: begin
               if (start_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (start_p) begin
                  state   <= STOP;
                  running <= 1'b0;
               end else if (lap_p) begin
                  state      <= LAP;
                  lap_active <= 1'b1;
                  lap_reg    <= live_cnt;
               end
            end
            LAP: begin
               if (start_p) begin
                  state      <= STOP;
                  running    <= 1'b0;
                  lap_active <= 1'b0;
               end else if (lap_p) begin
                  state      <= RUN;
                  lap_active <= 1'b0;
               end
            end
            STOP: begin
               if (clear_p) begin
                  state    <= IDLE;
                  presc    <= '0;
                  live_cnt <= '0;
                  lap_reg  <= '0;
               end else if (start_p) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               running    <= 1'b0;
               lap_active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: an integer-hundredths reference model
// feeds a scoreboard queue that is compared against the DUT every cycle.
module tb_stopwatch_ctrl;

   localparam int TICK_DIV  = 4;
   localparam int WRAP_HUND = 360000;
   localparam int S_IDLE    = 0;
   localparam int S_RUN     = 1;
   localparam int S_STOP    = 2;
   localparam int S_LAP     = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_p;
   logic        lap_p;
   logic        clear_p;
   logic [23:0] disp_bcd;
   logic        running;
   logic        lap_active;
   logic        wrap_p;

   stopwatch_ctrl #(
      .TICK_DIV(TICK_DIV),
      .CNT_W   (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_p   (start_p),
      .lap_p     (lap_p),
      .clear_p   (clear_p),
      .disp_bcd  (disp_bcd),
      .running   (running),
      .lap_active(lap_active),
      .wrap_p    (wrap_p)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [23:0] disp;
      logic        run;
      logic        lapact;
      logic        wrap;
   } exp_t;

   exp_t  exp_q[$];
   int    check_count = 0;
   int    error_count = 0;
   string phase = "init";

   int          m_state;
   int          m_presc;
   int          m_count;
   int          m_lap;
   logic [23:0] m_disp;
   logic        m_wrap;
   logic        m_wrap_pend;

   function automatic logic [23:0] to_bcd(input int h);
      int mm, ss, cc;
      mm = h / 6000;
      ss = (h / 100) % 60;
      cc = h % 100;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
   endfunction

   function automatic void model_reset();
      m_state     = S_IDLE;
      m_presc     = 0;
      m_count     = 0;
      m_lap       = 0;
      m_disp      = '0;
      m_wrap      = 1'b0;
      m_wrap_pend = 1'b0;
   endfunction

   // One clock edge of the reference behaviour, using pre-edge model values
   function automatic void model_step(input logic s, input logic l, input logic c);
      bit live;
      bit tick;
      int old_count;
      live      = (m_state == S_RUN) || (m_state == S_LAP);
      tick      = live && (m_presc == TICK_DIV - 1);
      m_disp    = (m_state == S_LAP) ? to_bcd(m_lap) : to_bcd(m_count);
      m_wrap    = m_wrap_pend;
      m_wrap_pend = tick && (m_count == WRAP_HUND - 1);
      old_count = m_count;
      if (live) m_presc = tick ? 0 : m_presc + 1;
      if (tick) m_count = (m_count + 1) % WRAP_HUND;
      case (m_state)
         S_IDLE: if (s) m_state = S_RUN;
         S_RUN: begin
            if (s) m_state = S_STOP;
            else if (l) begin
               m_state = S_LAP;
               m_lap   = old_count;
            end
         end
         S_LAP: begin
            if (s) m_state = S_STOP;
            else if (l) m_state = S_RUN;
         end
         default: begin
            if (c) begin
               m_state = S_IDLE;
               m_presc = 0;
               m_count = 0;
               m_lap   = 0;
            end else if (s) m_state = S_RUN;
         end
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [23:0] actual, input logic [23:0] expected);
      check_count++;
      if (actual !== expected) begin
         error_count++;
         $display("[TB] FAIL %s/%s: actual=%h expected=%h at %0t", phase, tag, actual, expected, $time);
      end
   endtask

   // Drive one cycle of pulses (called at negedge), score the DUT at the next negedge
   task automatic applyStimulus(input logic s, input logic l, input logic c);
      exp_t e;
      start_p = s;
      lap_p   = l;
      clear_p = c;
      @(posedge clk);
      model_step(s, l, c);
      e.disp   = m_disp;
      e.run    = (m_state == S_RUN) || (m_state == S_LAP);
      e.lapact = (m_state == S_LAP);
      e.wrap   = m_wrap;
      exp_q.push_back(e);
      @(negedge clk);
      start_p = 1'b0;
      lap_p   = 1'b0;
      clear_p = 1'b0;
      e = exp_q.pop_front();
      checkOutput("disp_bcd", disp_bcd, e.disp);
      checkOutput("running", 24'(running), 24'(e.run));
      checkOutput("lap_active", 24'(lap_active), 24'(e.lapact));
      checkOutput("wrap_p", 24'(wrap_p), 24'(e.wrap));
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int wrap_seen;
      rst     = 1'b1;
      start_p = 1'b0;
      lap_p   = 1'b0;
      clear_p = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      phase = "reset";
      checkOutput("disp_bcd", disp_bcd, 24'h000000);
      checkOutput("running", 24'(running), 24'h0);
      checkOutput("lap_active", 24'(lap_active), 24'h0);
      checkOutput("wrap_p", 24'(wrap_p), 24'h0);
      rst = 1'b0;

      phase = "tp1_start";
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("running_next", 24'(running), 24'h1);
      runCycles(5);
      checkOutput("disp_first_tick", disp_bcd, 24'h000001);
      runCycles(36);
      checkOutput("disp_ten_ticks", disp_bcd, 24'h000010);

      phase = "tp2_lap";
      runCycles(59);
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(1);
      checkOutput("disp_frozen", disp_bcd, 24'h000025);
      checkOutput("lap_active_on", 24'(lap_active), 24'h1);
      runCycles(38);
      checkOutput("disp_still_frozen", disp_bcd, 24'h000025);
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(1);
      checkOutput("disp_live_again", disp_bcd, 24'h000035);
      checkOutput("lap_active_off", 24'(lap_active), 24'h0);

      phase = "tp4_clear";
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCycles(3);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      runCycles(6);
      applyStimulus(1'b0, 1'b0, 1'b1);
      runCycles(1);
      checkOutput("disp_cleared", disp_bcd, 24'h000000);
      checkOutput("running_idle", 24'(running), 24'h0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1);

      phase = "tp5_priority";
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(9);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(2);
      applyStimulus(1'b1, 1'b0, 1'b1);
      runCycles(1);
      checkOutput("clear_beats_start", 24'(running), 24'h0);
      checkOutput("clear_beats_start_disp", disp_bcd, 24'h000000);
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(7);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("start_beats_lap", 24'(lap_active), 24'h0);
      checkOutput("start_beats_lap_run", 24'(running), 24'h0);

      phase = "tp3_wrap";
      force dut.live_cnt = 24'h595990;
      m_count = 359990;
      applyStimulus(1'b0, 1'b0, 1'b0);
      release dut.live_cnt;
      applyStimulus(1'b1, 1'b0, 1'b0);
      wrap_seen = 0;
      for (int i = 0; i < 60; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         if (wrap_p) wrap_seen++;
      end
      checkOutput("wrap_pulse_count", 24'(wrap_seen), 24'h1);
      checkOutput("running_after_wrap", 24'(running), 24'h1);

      phase = "random";
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 11) == 0));
      end

      phase = "tp6_async_reset";
      if (m_state != S_LAP) begin
         if (m_state != S_RUN) applyStimulus(1'b1, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      runCycles(5);
      checkOutput("in_lap", 24'(lap_active), 24'h1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checkOutput("disp_async", disp_bcd, 24'h000000);
      checkOutput("running_async", 24'(running), 24'h0);
      checkOutput("lap_active_async", 24'(lap_active), 24'h0);
      checkOutput("wrap_async", 24'(wrap_p), 24'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      runCycles(10);
      checkOutput("resume_from_zero", disp_bcd, 24'h000002);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
